// File: rtl/if_fetch_stage_if.sv
// if_fetch_stage_if: instruction-memory req/ack bus between the fetch stage and imem
interface if_fetch_stage_if;
   logic        req;
   logic [31:0] addr;
   logic        ack;
   logic [31:0] rdata;
   modport master(output req, addr, input ack, rdata);
   modport slave(input req, addr, output ack, rdata);
endinterface

// File: rtl/if_fetch_stage.sv
// if_fetch_stage: MIPS IF stage owning the PC, fetching over req/ack and feeding IF/ID
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     stall,
   input  logic                     redirect,
   input  logic [31:0]              redirect_pc,
   if_fetch_stage_if.master         imem,
   output logic [31:0]              PCplus4,
   output logic [31:0]              Instruction,
   output logic                     if_valid
);
   typedef enum logic [1:0] {FETCH, HOLD, DISCARD} state_t;
   state_t state, state_n;
   logic [31:0] pc, pc_n, pend_pc, pend_n, skid, skid_n, pcp4_n, instr_n;
   logic        valid_n;
   logic [31:0] pc_inc;
   assign pc_inc    = pc + 32'd4;
   assign imem.req  = !rst && state != HOLD;
   assign imem.addr = pc;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= FETCH;
         pc          <= RESET_PC;
         pend_pc     <= '0;
         skid        <= '0;
         PCplus4     <= '0;
         Instruction <= NOP_INSTR;
         if_valid    <= 1'b0;
      end else begin
         state       <= state_n;
         pc          <= pc_n;
         pend_pc     <= pend_n;
         skid        <= skid_n;
         PCplus4     <= pcp4_n;
         Instruction <= instr_n;
         if_valid    <= valid_n;
      end
   end
   always_comb begin
      state_n = state;
      pc_n    = pc;
      pend_n  = pend_pc;
      skid_n  = skid;
      pcp4_n  = PCplus4;
      instr_n = Instruction;
      valid_n = if_valid;
      case (state)
         FETCH: begin
            if (redirect) begin
               instr_n = NOP_INSTR;
               valid_n = 1'b0;
               if (imem.ack) pc_n = redirect_pc;
               else begin
                  pend_n  = redirect_pc;
                  state_n = DISCARD;
               end
            end else if (stall) begin
               // an ack under stall is parked in skid so it is neither lost nor replayed
               if (imem.ack) begin
                  skid_n  = imem.rdata;
                  pc_n    = pc_inc;
                  state_n = HOLD;
               end
            end else begin
               instr_n = imem.ack ? imem.rdata : NOP_INSTR;
               valid_n = imem.ack;
               if (imem.ack) begin
                  pcp4_n = pc_inc;
                  pc_n   = pc_inc;
               end
            end
         end
         HOLD: begin
            if (redirect) begin
               pc_n    = redirect_pc;
               instr_n = NOP_INSTR;
               valid_n = 1'b0;
               state_n = FETCH;
            end else if (!stall) begin
               instr_n = skid;
               pcp4_n  = pc;
               valid_n = 1'b1;
               state_n = FETCH;
            end
         end
         DISCARD: begin
            instr_n = NOP_INSTR;
            valid_n = 1'b0;
            // the wrong-path request must still complete before the new target is fetched
            if (imem.ack) begin
               pc_n    = redirect ? redirect_pc : pend_pc;
               state_n = FETCH;
            end else if (redirect) pend_n = redirect_pc;
         end
         default: state_n = FETCH;
      endcase
   end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed tests of the fetch stage with a hand-driven instruction memory
module tb_if_fetch_stage;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        stall = 1'b0;
   logic        redirect = 1'b0;
   logic [31:0] redirect_pc = '0;
   logic [31:0] PCplus4, Instruction;
   logic        if_valid;
   int          checks = 0;
   int          errors = 0;
   if_fetch_stage_if imem();
   if_fetch_stage #(.RESET_PC(32'h0040_0000), .NOP_INSTR(32'h0000_0000)) dut (
      .clk(clk), .rst(rst), .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
      .imem(imem), .PCplus4(PCplus4), .Instruction(Instruction), .if_valid(if_valid)
   );
   always #5 clk = ~clk;

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset;
      imem.ack = 1'b0;
      imem.rdata = '0;
      #12;
      checks++; if (PCplus4 !== 32'h0) begin errors++; $display("FAIL reset_pc4 got %h exp %h", PCplus4, 32'h0); end
      checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL reset_instr got %h exp %h", Instruction, 32'h0); end
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", if_valid); end
      checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL reset_req got %b exp 0", imem.req); end
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL first_req got %b exp 1", imem.req); end
      checks++; if (imem.addr !== 32'h0040_0000) begin errors++; $display("FAIL first_addr got %h exp %h", imem.addr, 32'h0040_0000); end
   endtask

   task automatic test_zero_wait;
      for (int i = 0; i < 4; i++) begin
         logic [31:0] e;
         e = 32'h0040_0000 + 32'(4 * i);
         imem.ack = 1'b1;
         imem.rdata = e ^ 32'hA5A5_0000;
         checks++; if (imem.addr !== e) begin errors++; $display("FAIL zw_addr%0d got %h exp %h", i, imem.addr, e); end
         step();
         checks++; if (PCplus4 !== e + 32'd4) begin errors++; $display("FAIL zw_pc4_%0d got %h exp %h", i, PCplus4, e + 32'd4); end
         checks++; if (Instruction !== (e ^ 32'hA5A5_0000)) begin errors++; $display("FAIL zw_instr%0d got %h exp %h", i, Instruction, e ^ 32'hA5A5_0000); end
         checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL zw_valid%0d got %b exp 1", i, if_valid); end
      end
      imem.ack = 1'b0;
   endtask

   task automatic test_wait_states;
      logic [31:0] prev;
      prev = 32'h0040_0010;
      for (int k = 0; k < 2; k++) begin
         logic [31:0] e;
         e = 32'h0040_0010 + 32'(4 * k);
         for (int c = 0; c < 2; c++) begin
            imem.ack = 1'b0;
            checks++; if (imem.addr !== e) begin errors++; $display("FAIL ws_addr_hold got %h exp %h", imem.addr, e); end
            step();
            checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL ws_bubble_valid got %b exp 0", if_valid); end
            checks++; if (Instruction !== 32'h0) begin errors++; $display("FAIL ws_bubble_instr got %h exp 0", Instruction); end
            checks++; if (PCplus4 !== prev) begin errors++; $display("FAIL ws_bubble_pc4 got %h exp %h", PCplus4, prev); end
         end
         imem.ack = 1'b1;
         imem.rdata = ~e;
         checks++; if (imem.addr !== e) begin errors++; $display("FAIL ws_addr_ack got %h exp %h", imem.addr, e); end
         step();
         checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL ws_valid got %b exp 1", if_valid); end
         checks++; if (Instruction !== ~e) begin errors++; $display("FAIL ws_instr got %h exp %h", Instruction, ~e); end
         checks++; if (PCplus4 !== e + 32'd4) begin errors++; $display("FAIL ws_pc4 got %h exp %h", PCplus4, e + 32'd4); end
         prev = e + 32'd4;
      end
      imem.ack = 1'b0;
   endtask

   task automatic test_stall;
      redirect = 1'b1;
      redirect_pc = 32'h0000_000C;
      imem.ack = 1'b1;
      imem.rdata = 32'hBAD0_0000;
      step();
      redirect = 1'b0;
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL st_redir_valid got %b exp 0", if_valid); end
      imem.rdata = 32'h1111_1111;
      checks++; if (imem.addr !== 32'hC) begin errors++; $display("FAIL st_addr_c got %h exp %h", imem.addr, 32'hC); end
      step();
      checks++; if (PCplus4 !== 32'h10) begin errors++; $display("FAIL st_pre_pc4 got %h exp %h", PCplus4, 32'h10); end
      stall = 1'b1;
      imem.ack = 1'b0;
      checks++; if (imem.addr !== 32'h10) begin errors++; $display("FAIL st_addr10 got %h exp %h", imem.addr, 32'h10); end
      step();
      checks++; if (imem.req !== 1'b1) begin errors++; $display("FAIL st_req_pending got %b exp 1", imem.req); end
      checks++; if (Instruction !== 32'h1111_1111) begin errors++; $display("FAIL st_hold_instr got %h exp %h", Instruction, 32'h1111_1111); end
      imem.ack = 1'b1;
      imem.rdata = 32'h2108_0001;
      step();
      imem.ack = 1'b0;
      for (int c = 0; c < 2; c++) begin
         checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL st_hold_req got %b exp 0", imem.req); end
         checks++; if (PCplus4 !== 32'h10) begin errors++; $display("FAIL st_frozen_pc4 got %h exp %h", PCplus4, 32'h10); end
         checks++; if (Instruction !== 32'h1111_1111) begin errors++; $display("FAIL st_frozen_instr got %h exp %h", Instruction, 32'h1111_1111); end
         checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL st_frozen_valid got %b exp 1", if_valid); end
         step();
      end
      stall = 1'b0;
      step();
      checks++; if (Instruction !== 32'h2108_0001) begin errors++; $display("FAIL st_rel_instr got %h exp %h", Instruction, 32'h2108_0001); end
      checks++; if (PCplus4 !== 32'h14) begin errors++; $display("FAIL st_rel_pc4 got %h exp %h", PCplus4, 32'h14); end
      checks++; if (if_valid !== 1'b1) begin errors++; $display("FAIL st_rel_valid got %b exp 1", if_valid); end
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h14) begin errors++; $display("FAIL st_next_req got %b/%h exp 1/%h", imem.req, imem.addr, 32'h14); end
   endtask

   task automatic test_redirect_discard;
      redirect = 1'b1;
      redirect_pc = 32'h20;
      imem.ack = 1'b1;
      imem.rdata = 32'h0BAD_0BAD;
      step();
      redirect = 1'b0;
      imem.ack = 1'b0;
      checks++; if (imem.addr !== 32'h20) begin errors++; $display("FAIL rd_addr20 got %h exp %h", imem.addr, 32'h20); end
      step();
      redirect = 1'b1;
      redirect_pc = 32'h0040_0100;
      step();
      redirect = 1'b0;
      checks++; if (if_valid !== 1'b0 || Instruction !== 32'h0) begin errors++; $display("FAIL rd_nop got %b/%h exp 0/0", if_valid, Instruction); end
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h20) begin errors++; $display("FAIL rd_old_addr got %b/%h exp 1/%h", imem.req, imem.addr, 32'h20); end
      step();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL rd_wait_valid got %b exp 0", if_valid); end
      imem.ack = 1'b1;
      imem.rdata = 32'hDEAD_BEEF;
      step();
      imem.ack = 1'b0;
      checks++; if (if_valid !== 1'b0 || Instruction !== 32'h0) begin errors++; $display("FAIL rd_dropped got %b/%h exp 0/0", if_valid, Instruction); end
      checks++; if (imem.addr !== 32'h0040_0100) begin errors++; $display("FAIL rd_new_addr got %h exp %h", imem.addr, 32'h0040_0100); end
      imem.ack = 1'b1;
      imem.rdata = 32'h1234_5678;
      step();
      imem.ack = 1'b0;
      checks++; if (Instruction !== 32'h1234_5678 || PCplus4 !== 32'h0040_0104) begin errors++; $display("FAIL rd_resume got %h/%h exp %h/%h", Instruction, PCplus4, 32'h1234_5678, 32'h0040_0104); end
   endtask

   task automatic test_redirect_priority;
      redirect = 1'b1;
      stall = 1'b1;
      redirect_pc = 32'h500;
      imem.ack = 1'b1;
      imem.rdata = 32'hCAFE_0000;
      step();
      imem.ack = 1'b0;
      checks++; if (if_valid !== 1'b0 || Instruction !== 32'h0) begin errors++; $display("FAIL pr_nop got %b/%h exp 0/0", if_valid, Instruction); end
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h500) begin errors++; $display("FAIL pr_addr got %b/%h exp 1/%h", imem.req, imem.addr, 32'h500); end
      stall = 1'b0;
      redirect_pc = 32'h600;
      step();
      redirect_pc = 32'h700;
      stall = 1'b1;
      step();
      checks++; if (if_valid !== 1'b0) begin errors++; $display("FAIL pr_disc_valid got %b exp 0", if_valid); end
      checks++; if (imem.addr !== 32'h500) begin errors++; $display("FAIL pr_disc_addr got %h exp %h", imem.addr, 32'h500); end
      redirect = 1'b0;
      stall = 1'b0;
      imem.ack = 1'b1;
      step();
      imem.ack = 1'b0;
      checks++; if (imem.addr !== 32'h700) begin errors++; $display("FAIL pr_latest got %h exp %h", imem.addr, 32'h700); end
      redirect = 1'b1;
      redirect_pc = 32'h800;
      step();
      redirect_pc = 32'h900;
      imem.ack = 1'b1;
      step();
      redirect = 1'b0;
      imem.ack = 1'b0;
      checks++; if (imem.addr !== 32'h900) begin errors++; $display("FAIL pr_coincident got %h exp %h", imem.addr, 32'h900); end
   endtask

   task automatic test_wrap;
      redirect = 1'b1;
      redirect_pc = 32'hFFFF_FFFC;
      imem.ack = 1'b1;
      step();
      redirect = 1'b0;
      imem.rdata = 32'h0BAD_F00D;
      checks++; if (imem.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wr_addr got %h exp %h", imem.addr, 32'hFFFF_FFFC); end
      step();
      checks++; if (PCplus4 !== 32'h0 || if_valid !== 1'b1) begin errors++; $display("FAIL wr_pc4 got %h/%b exp 0/1", PCplus4, if_valid); end
      checks++; if (imem.addr !== 32'h0) begin errors++; $display("FAIL wr_next_addr got %h exp 0", imem.addr); end
      redirect = 1'b1;
      redirect_pc = 32'h102;
      step();
      redirect = 1'b0;
      imem.rdata = 32'h0000_0055;
      checks++; if (imem.addr !== 32'h102) begin errors++; $display("FAIL wr_unaligned_addr got %h exp %h", imem.addr, 32'h102); end
      step();
      imem.ack = 1'b0;
      checks++; if (PCplus4 !== 32'h106) begin errors++; $display("FAIL wr_unaligned_pc4 got %h exp %h", PCplus4, 32'h106); end
   endtask

   task automatic test_async_reset;
      stall = 1'b1;
      step();
      #3;
      rst = 1'b1;
      #1;
      checks++; if (PCplus4 !== 32'h0 || Instruction !== 32'h0 || if_valid !== 1'b0) begin errors++; $display("FAIL ar_outputs got %h/%h/%b exp 0/0/0", PCplus4, Instruction, if_valid); end
      checks++; if (imem.req !== 1'b0) begin errors++; $display("FAIL ar_req got %b exp 0", imem.req); end
      stall = 1'b0;
      @(negedge clk);
      rst = 1'b0;
      #1;
      checks++; if (imem.req !== 1'b1 || imem.addr !== 32'h0040_0000) begin errors++; $display("FAIL ar_restart got %b/%h exp 1/%h", imem.req, imem.addr, 32'h0040_0000); end
      imem.ack = 1'b1;
      imem.rdata = 32'h0000_0077;
      step();
      imem.ack = 1'b0;
      checks++; if (PCplus4 !== 32'h0040_0004 || Instruction !== 32'h77) begin errors++; $display("FAIL ar_first_fetch got %h/%h exp %h/%h", PCplus4, Instruction, 32'h0040_0004, 32'h77); end
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_wait_states();
      test_stall();
      test_redirect_discard();
      test_redirect_priority();
      test_wrap();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
